// File: rtl/tracker_pkg.sv
// Shared widths, init values, HSV field positions and types for hsv_bbox_tracker.
package tracker_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 20;

  localparam logic [COORD_W-1:0] COORD_INIT_MIN = 11'd2047;
  localparam logic [COORD_W-1:0] COORD_INIT_MAX = 11'd0;
  localparam logic [COORD_W-1:0] COORD_SAT      = 11'd2047;
  localparam logic [CNT_W-1:0]   CNT_SAT        = 20'hFFFFF;

  localparam int H_MSB = 23;
  localparam int H_LSB = 16;
  localparam int S_MSB = 15;
  localparam int S_LSB = 8;
  localparam int V_MSB = 7;
  localparam int V_LSB = 0;

  typedef enum logic {
    ST_ARM = 1'b0,
    ST_RUN = 1'b1
  } pub_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_y;
    logic [CNT_W-1:0]   cnt;
  } box_t;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        clken;
    logic [23:0] rgb;
    logic        mask;
  } strm_t;

  localparam box_t BOX_INIT = '{
    min_x: COORD_INIT_MIN,
    max_x: COORD_INIT_MAX,
    min_y: COORD_INIT_MIN,
    max_y: COORD_INIT_MAX,
    cnt:   20'd0
  };

  localparam strm_t STRM_IDLE = '{
    vs:    1'b0,
    hs:    1'b0,
    clken: 1'b0,
    rgb:   24'h000000,
    mask:  1'b0
  };

  function automatic logic [COORD_W-1:0] coord_inc(input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] r;
    if (c == COORD_SAT) begin
      r = c;
    end else begin
      r = c + 11'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hsv_range_cmp.sv
// Combinational H/S/V window test; a window with h_min > h_max wraps through red.
module hsv_range_cmp
  import tracker_pkg::*;
(
  input  logic [23:0] hsv,
  input  logic [7:0]  h_min,
  input  logic [7:0]  h_max,
  input  logic [7:0]  s_min,
  input  logic [7:0]  v_min,
  output logic        match
);

  logic [7:0] h_val;
  logic [7:0] s_val;
  logic [7:0] v_val;
  logic       hue_ok;

  always_comb begin
    h_val = hsv[H_MSB:H_LSB];
    s_val = hsv[S_MSB:S_LSB];
    v_val = hsv[V_MSB:V_LSB];
    if (h_min <= h_max) begin
      hue_ok = (h_val >= h_min) && (h_val <= h_max);
    end else begin
      hue_ok = (h_val >= h_min) || (h_val <= h_max);
    end
    match = (s_val >= s_min) && (v_val >= v_min) && hue_ok;
  end

endmodule

// File: rtl/hsv_bbox_tracker.sv
// Colour-gated object locator: 2-stage HSV/RGB pass-through plus per-frame bounding box.
// Define HSV_BBOX_OVERLAY_EN to draw the previous frame's box onto post_rgb.
module hsv_bbox_tracker
  import tracker_pkg::*;
#(
  parameter int          IMG_W      = 800,
  parameter int          IMG_H      = 600,
  parameter int          MIN_PIXELS = 64,
  parameter logic [23:0] BOX_RGB    = 24'hFF0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pre_vs,
  input  logic                pre_hs,
  input  logic                pre_clken,
  input  logic [23:0]         hsv,
  input  logic [23:0]         rgb,
  input  logic [7:0]          h_min,
  input  logic [7:0]          h_max,
  input  logic [7:0]          s_min,
  input  logic [7:0]          v_min,
  output logic                post_vs,
  output logic                post_hs,
  output logic                post_clken,
  output logic [23:0]         post_rgb,
  output logic                post_mask,
  output logic [COORD_W-1:0]  bbox_x0,
  output logic [COORD_W-1:0]  bbox_x1,
  output logic [COORD_W-1:0]  bbox_y0,
  output logic [COORD_W-1:0]  bbox_y1,
  output logic [CNT_W-1:0]    bbox_cnt,
  output logic                bbox_found,
  output logic                bbox_valid
);

  localparam logic [COORD_W-1:0] X_LIM   = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] Y_LIM   = COORD_W'(IMG_H);
  localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIXELS);

  logic               cmp_match;
  logic               vs_rise;
  logic               pix_hit;
  logic [COORD_W-1:0] x_d, x_q, y_d, y_q;
  strm_t              s1_d, s1_q, s2_d, s2_q;
  box_t               acc_d, acc_q, bbox_d, bbox_q;
  pub_state_e         state_d, state_q;
  logic               found_d, found_q, valid_d, valid_q;

  hsv_range_cmp u_cmp (
    .hsv   (hsv),
    .h_min (h_min),
    .h_max (h_max),
    .s_min (s_min),
    .v_min (v_min),
    .match (cmp_match)
  );

  // s1_q.vs / s1_q.clken double as the previous-cycle syncs for edge detection
  always_comb begin
    vs_rise = pre_vs & ~s1_q.vs;
    pix_hit = cmp_match & pre_clken & ~pre_vs & (x_q < X_LIM) & (y_q < Y_LIM);
  end

  // Holding the counters clear for all of vsync keeps a clken edge there from skewing y
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pre_vs) begin
      x_d = {COORD_W{1'b0}};
      y_d = {COORD_W{1'b0}};
    end else if (pre_clken) begin
      x_d = coord_inc(x_q);
    end else if (s1_q.clken) begin
      x_d = {COORD_W{1'b0}};
      y_d = coord_inc(y_q);
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bbox_d  = bbox_q;
    found_d = found_q;
    valid_d = 1'b0;
    if (vs_rise) begin
      acc_d = BOX_INIT;
      case (state_q)
        ST_ARM: state_d = ST_RUN;
        ST_RUN: begin
          bbox_d  = acc_q;
          found_d = (acc_q.cnt >= MIN_CNT);
          valid_d = 1'b1;
        end
        default: state_d = ST_ARM;
      endcase
    end else if (pix_hit) begin
      if (x_q < acc_q.min_x) acc_d.min_x = x_q; else acc_d.min_x = acc_q.min_x;
      if (x_q > acc_q.max_x) acc_d.max_x = x_q; else acc_d.max_x = acc_q.max_x;
      if (y_q < acc_q.min_y) acc_d.min_y = y_q; else acc_d.min_y = acc_q.min_y;
      if (y_q > acc_q.max_y) acc_d.max_y = y_q; else acc_d.max_y = acc_q.max_y;
      if (acc_q.cnt != CNT_SAT) acc_d.cnt = acc_q.cnt + 20'd1; else acc_d.cnt = acc_q.cnt;
    end else begin
      acc_d = acc_q;
    end
  end

  always_comb begin
    s1_d = '{vs: pre_vs, hs: pre_hs, clken: pre_clken, rgb: rgb, mask: pix_hit};
  end

`ifdef HSV_BBOX_OVERLAY_EN
  logic [COORD_W-1:0] s1_x_q, s1_y_q;
  logic               on_col, on_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x_q <= {COORD_W{1'b0}};
      s1_y_q <= {COORD_W{1'b0}};
    end else begin
      s1_x_q <= x_q;
      s1_y_q <= y_q;
    end
  end

  // Box published at the last vs rise is drawn over the frame that follows it
  always_comb begin
    on_col = ((s1_x_q == bbox_q.min_x) || (s1_x_q == bbox_q.max_x)) &&
             (s1_y_q >= bbox_q.min_y) && (s1_y_q <= bbox_q.max_y);
    on_row = ((s1_y_q == bbox_q.min_y) || (s1_y_q == bbox_q.max_y)) &&
             (s1_x_q >= bbox_q.min_x) && (s1_x_q <= bbox_q.max_x);
    s2_d = s1_q;
    if (found_q && s1_q.clken && !s1_q.vs && (on_col || on_row)) begin
      s2_d.rgb = BOX_RGB;
    end else begin
      s2_d.rgb = s1_q.rgb;
    end
  end
`else
  always_comb begin
    s2_d = s1_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= {COORD_W{1'b0}};
      y_q     <= {COORD_W{1'b0}};
      s1_q    <= STRM_IDLE;
      s2_q    <= STRM_IDLE;
      acc_q   <= BOX_INIT;
      bbox_q  <= BOX_INIT;
      state_q <= ST_ARM;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      acc_q   <= acc_d;
      bbox_q  <= bbox_d;
      state_q <= state_d;
      found_q <= found_d;
      valid_q <= valid_d;
    end
  end

  assign post_vs    = s2_q.vs;
  assign post_hs    = s2_q.hs;
  assign post_clken = s2_q.clken;
  assign post_rgb   = s2_q.rgb;
  assign post_mask  = s2_q.mask;
  assign bbox_x0    = bbox_q.min_x;
  assign bbox_x1    = bbox_q.max_x;
  assign bbox_y0    = bbox_q.min_y;
  assign bbox_y1    = bbox_q.max_y;
  assign bbox_cnt   = bbox_q.cnt;
  assign bbox_found = found_q;
  assign bbox_valid = valid_q;

endmodule

// File: tb/tb_hsv_bbox_tracker.sv
// Bench for hsv_bbox_tracker: table of directed/random frames checked against a
// frame-level reference model of the match, box and publish rules.
module tb_hsv_bbox_tracker;

  localparam int W      = 40;
  localparam int H      = 30;
  localparam int MINP   = 64;
  localparam int LINE   = W + 2;
  localparam int NLINES = H + 1;
  localparam int HGAP   = 4;
  localparam logic [23:0] MPIX = {8'd10, 8'd200, 8'd200};
  localparam logic [23:0] GREY = {8'd0, 8'd0, 8'd128};

  logic        clk = 1'b0;
  logic        rst, pre_vs, pre_hs, pre_clken;
  logic [23:0] hsv, rgb;
  logic [7:0]  h_min, h_max, s_min, v_min;
  logic        post_vs, post_hs, post_clken, post_mask;
  logic [23:0] post_rgb;
  logic [10:0] bbox_x0, bbox_x1, bbox_y0, bbox_y1;
  logic [19:0] bbox_cnt;
  logic        bbox_found, bbox_valid;

  always #5 clk = ~clk;

  hsv_bbox_tracker #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(MINP), .BOX_RGB(24'hFF0000)) dut (
    .clk(clk), .rst(rst), .pre_vs(pre_vs), .pre_hs(pre_hs), .pre_clken(pre_clken),
    .hsv(hsv), .rgb(rgb), .h_min(h_min), .h_max(h_max), .s_min(s_min), .v_min(v_min),
    .post_vs(post_vs), .post_hs(post_hs), .post_clken(post_clken), .post_rgb(post_rgb),
    .post_mask(post_mask), .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0),
    .bbox_y1(bbox_y1), .bbox_cnt(bbox_cnt), .bbox_found(bbox_found), .bbox_valid(bbox_valid)
  );

  typedef struct packed {
    logic vs; logic hs; logic ce; logic [23:0] rgb; logic mask;
  } sv_t;

  typedef struct {
    int mode; logic [7:0] hmin; logic [7:0] hmax; logic [7:0] smin; logic [7:0] vmin;
    bit rnd; bit ce_rise; bit use_tab;
    int x0; int x1; int y0; int y1; int cnt; bit found;
  } vec_t;

  int    n_checks = 0;
  int    n_err = 0;
  int    m_x0, m_x1, m_y0, m_y1, m_cnt;
  int    p_x0, p_x1, p_y0, p_y1, p_cnt;
  bit    p_found, armed, last_vs, exp_valid, chk_stream;
  sv_t   prev_in;
  int    stream_errs;
  string first_bad;
  int    valid_pulses;
  int    cap_x0, cap_x1, cap_y0, cap_y1, cap_cnt;
  bit    cap_found;
  vec_t  tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    n_checks++;
    if (stream_errs != 0) begin
      n_err++;
      $display("FAIL stream_%s: %0d bad cycles, want 0 (first: %s)", tag, stream_errs, first_bad);
    end
    stream_errs = 0;
  endtask

  function automatic bit ref_match(input logic [23:0] p, input logic [7:0] hmin,
                                   input logic [7:0] hmax, input logic [7:0] smin,
                                   input logic [7:0] vmin);
    int hh, ss, vv;
    bit hue;
    hh = int'(p[23:16]); ss = int'(p[15:8]); vv = int'(p[7:0]);
    if (hmin <= hmax) hue = (hh >= int'(hmin)) && (hh <= int'(hmax));
    else              hue = (hh >= int'(hmin)) || (hh <= int'(hmax));
    return (ss >= int'(smin)) && (vv >= int'(vmin)) && hue;
  endfunction

`ifdef HSV_BBOX_OVERLAY_EN
  function automatic bit on_perim(input int x, input int y);
    return ((x == p_x0 || x == p_x1) && y >= p_y0 && y <= p_y1) ||
           ((y == p_y0 || y == p_y1) && x >= p_x0 && x <= p_x1);
  endfunction
`endif

  task automatic m_init();
    m_x0 = 2047; m_x1 = 0; m_y0 = 2047; m_y1 = 0; m_cnt = 0;
  endtask

  // One clock: update the model for the pixel on the inputs, clock it, compare.
  task automatic step(input int px, input int py);
    bit          m;
    logic [23:0] erg;
    sv_t         cur, act;
    m = pre_clken && !pre_vs && px < W && py < H && ref_match(hsv, h_min, h_max, s_min, v_min);
    exp_valid = 1'b0;
    if (pre_vs && !last_vs) begin
      if (armed) begin
        p_x0 = m_x0; p_x1 = m_x1; p_y0 = m_y0; p_y1 = m_y1; p_cnt = m_cnt;
        p_found = (m_cnt >= MINP);
        exp_valid = 1'b1;
      end
      armed = 1'b1;
      m_init();
    end else if (m) begin
      if (px < m_x0) m_x0 = px;
      if (px > m_x1) m_x1 = px;
      if (py < m_y0) m_y0 = py;
      if (py > m_y1) m_y1 = py;
      if (m_cnt < 1048575) m_cnt++;
    end
    last_vs = pre_vs;
    erg = rgb;
`ifdef HSV_BBOX_OVERLAY_EN
    if (p_found && pre_clken && !pre_vs && on_perim(px, py)) erg = 24'hFF0000;
`endif
    cur = '{vs: pre_vs, hs: pre_hs, ce: pre_clken, rgb: erg, mask: m};
    @(posedge clk);
    #1;
    act = {post_vs, post_hs, post_clken, post_rgb, post_mask};
    if (chk_stream && (act !== prev_in || bbox_valid !== exp_valid)) begin
      if (stream_errs == 0)
        first_bad = $sformatf("post=%h want %h valid=%b want %b", act, prev_in, bbox_valid, exp_valid);
      stream_errs++;
    end
    if (bbox_valid === 1'b1) begin
      valid_pulses++;
      cap_x0 = int'(bbox_x0); cap_x1 = int'(bbox_x1);
      cap_y0 = int'(bbox_y0); cap_y1 = int'(bbox_y1);
      cap_cnt = int'(bbox_cnt); cap_found = bbox_found;
    end
    prev_in = cur;
  endtask

  task automatic do_reset();
    rst = 1'b1; pre_vs = 1'b0; pre_hs = 1'b0; pre_clken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    armed = 1'b0; last_vs = 1'b0; prev_in = '0; m_init();
    p_x0 = 2047; p_x1 = 0; p_y0 = 2047; p_y1 = 0; p_cnt = 0; p_found = 1'b0;
  endtask

  task automatic send_vs(input bit ce_rise);
    valid_pulses = 0;
    pre_vs = 1'b1; pre_hs = 1'b1; pre_clken = ce_rise; hsv = MPIX; rgb = 24'h123456;
    step(0, 0);
    chk_stream = 1'b1;
    pre_clken = 1'b0;
    repeat (2) step(0, 0);
    pre_vs = 1'b0; pre_hs = 1'b0;
    repeat (2) step(0, 0);
  endtask

  task automatic set_pix(input int mode, input int x, input int y);
    logic [7:0] hh;
    rgb = {8'(x), 8'(y), 8'hA5};
    case (mode)
      0: hsv = MPIX;
      1: hsv = (x >= 10 && x < 30 && y >= 5 && y < 15) ? MPIX : GREY;
      2: begin
        hh = (x % 3 == 0) ? 8'd252 : ((x % 3 == 1) ? 8'd3 : 8'd128);
        hsv = {hh, 8'd200, 8'd200};
      end
      3: hsv = (y == 2 && x < 30) ? MPIX : GREY;
      4: hsv = GREY;
      default: hsv = 24'($urandom);
    endcase
  endtask

  task automatic send_lines(input int mode, input bit rnd, input int nl);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < LINE; x++) begin
        if (rnd && (x % 8 == 0)) begin
          h_min = 8'($urandom); h_max = 8'($urandom);
          s_min = 8'($urandom_range(0, 150)); v_min = 8'($urandom_range(0, 150));
        end
        pre_clken = 1'b1; pre_hs = 1'b0;
        set_pix(mode, x, y);
        step(x, y);
      end
      pre_clken = 1'b0; pre_hs = 1'b1;
      for (int g = 0; g < HGAP; g++) begin
        hsv = 24'($urandom); rgb = 24'($urandom);
        step(0, 0);
      end
    end
  endtask

  initial begin
    tab[0] = '{0, 8'd0,   8'd20, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 0,    39, 0,    29, 1200, 1'b1};
    tab[1] = '{1, 8'd0,   8'd20, 8'd100, 8'd100, 1'b0, 1'b1, 1'b1, 10,   29, 5,    14, 200,  1'b1};
    tab[2] = '{2, 8'd250, 8'd5,  8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 0,    39, 0,    29, 810,  1'b1};
    tab[3] = '{3, 8'd0,   8'd20, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 0,    29, 2,    2,  30,   1'b0};
    tab[4] = '{4, 8'd0,   8'd20, 8'd100, 8'd100, 1'b0, 1'b1, 1'b1, 2047, 0,  2047, 0,  0,    1'b0};
    for (int i = 5; i < 8; i++)
      tab[i] = '{5, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0};

    rst = 1'b0; pre_vs = 1'b0; pre_hs = 1'b0; pre_clken = 1'b0; hsv = '0; rgb = '0;
    h_min = 8'd0; h_max = 8'd20; s_min = 8'd100; v_min = 8'd100;
    chk_stream = 1'b1; stream_errs = 0; first_bad = "";
    do_reset();

    check("rst_post", {7'd0, post_vs, post_hs, post_clken, post_rgb, post_mask}, 32'd0);
    check("rst_x0", bbox_x0, 2047);
    check("rst_x1", bbox_x1, 0);
    check("rst_y0", bbox_y0, 2047);
    check("rst_y1", bbox_y1, 0);
    check("rst_cnt", bbox_cnt, 0);
    check("rst_found_valid", {bbox_found, bbox_valid}, 0);

    send_vs(1'b0);
    check("arm_no_valid", valid_pulses, 0);
    check_stream("arm");

    for (int e = 0; e < 8; e++) begin
      h_min = tab[e].hmin; h_max = tab[e].hmax; s_min = tab[e].smin; v_min = tab[e].vmin;
      send_lines(tab[e].mode, tab[e].rnd, NLINES);
      check("hold_cnt", bbox_cnt, p_cnt);
      check("hold_x0", bbox_x0, p_x0);
      send_vs(tab[e].ce_rise);
      check("valid_pulses", valid_pulses, 1);
      check("mdl_x0", cap_x0, p_x0);
      check("mdl_x1", cap_x1, p_x1);
      check("mdl_y0", cap_y0, p_y0);
      check("mdl_y1", cap_y1, p_y1);
      check("mdl_cnt", cap_cnt, p_cnt);
      check("mdl_found", cap_found, p_found);
      if (tab[e].use_tab) begin
        check("tab_x0", cap_x0, tab[e].x0);
        check("tab_x1", cap_x1, tab[e].x1);
        check("tab_y0", cap_y0, tab[e].y0);
        check("tab_y1", cap_y1, tab[e].y1);
        check("tab_cnt", cap_cnt, tab[e].cnt);
        check("tab_found", cap_found, tab[e].found);
      end
      check_stream($sformatf("frame%0d", e));
    end

    // Reset in the middle of a frame: that frame and the next rise publish nothing
    h_min = 8'd0; h_max = 8'd20; s_min = 8'd100; v_min = 8'd100;
    send_lines(0, 1'b0, 15);
    chk_stream = 1'b0;
    do_reset();
    check("midrst_x0", bbox_x0, 2047);
    check("midrst_cnt", bbox_cnt, 0);
    send_lines(0, 1'b0, NLINES - 15);
    send_vs(1'b0);
    check("midrst_no_valid", valid_pulses, 0);
    send_lines(0, 1'b0, NLINES);
    send_vs(1'b0);
    check("post_rst_valid", valid_pulses, 1);
    check("post_rst_cnt", cap_cnt, W * H);
    check("post_rst_x1", cap_x1, W - 1);
    check("post_rst_y1", cap_y1, H - 1);
    check("post_rst_found", cap_found, 1);
    check_stream("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
